// File: rtl/change_disp_pkg.sv
//==== change_disp_pkg -- shared coin codes, coin values and payout state type
//==== rev 1.0
`default_nettype none

package change_disp_pkg;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_1    = 2'b01;
  localparam logic [1:0] COIN_5    = 2'b10;
  localparam logic [1:0] COIN_10   = 2'b11;

  localparam logic [5:0] COIN_VAL_1  = 6'd1;
  localparam logic [5:0] COIN_VAL_5  = 6'd5;
  localparam logic [5:0] COIN_VAL_10 = 6'd10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PICK  = 2'd1,
    ST_ISSUE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/change_dispenser_coin_select.sv
//==== coin_select -- greedy 10/5/1 choice; stock counts only matter when stock_en is high
//==== rev 1.0
`default_nettype none

module coin_select
  import change_disp_pkg::*;
#(
  parameter int STOCK_W = 4
) (
  input  logic [5:0]         remaining,
  input  logic [STOCK_W-1:0] stock10,
  input  logic [STOCK_W-1:0] stock5,
  input  logic               stock_en,
  output logic [1:0]         coin_code,
  output logic [5:0]         coin_val
);

  logic has10;
  logic has5;

  always_comb begin
    has10     = !stock_en || (stock10 != '0);
    has5      = !stock_en || (stock5 != '0);
    coin_code = COIN_1;
    coin_val  = COIN_VAL_1;
    if ((remaining >= COIN_VAL_10) && has10) begin
      coin_code = COIN_10;
      coin_val  = COIN_VAL_10;
    end else if ((remaining >= COIN_VAL_5) && has5) begin
      coin_code = COIN_5;
      coin_val  = COIN_VAL_5;
    end
  end

endmodule

`default_nettype wire

// File: rtl/change_dispenser.sv
//==== change_dispenser -- pays a change amount out as coins over a valid/ack handshake
//==== rev 1.0; stock counters and refill exist only with CHANGE_DISPENSER_STOCK_EN defined
`default_nettype none

module change_dispenser
  import change_disp_pkg::*;
#(
  parameter int STOCK10_INIT = 8,
  parameter int STOCK5_INIT  = 8,
  parameter int STOCK_W      = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  input  logic [5:0]         req_amt,
  output logic               req_ready,
  output logic               coin_valid,
  output logic [1:0]         coin_code,
  input  logic               coin_ack,
  output logic [5:0]         remaining,
  output logic               done
`ifdef CHANGE_DISPENSER_STOCK_EN
  ,
  input  logic               refill,
  output logic [STOCK_W-1:0] stock10,
  output logic [STOCK_W-1:0] stock5
`endif
);

  localparam logic [STOCK_W-1:0] STOCK10_RST = STOCK_W'(STOCK10_INIT);
  localparam logic [STOCK_W-1:0] STOCK5_RST  = STOCK_W'(STOCK5_INIT);

  state_t             state_q, state_d;
  logic [5:0]         remaining_q, remaining_d;
  logic [1:0]         code_q, code_d;
  logic [5:0]         val_q, val_d;
  logic [STOCK_W-1:0] stock10_cnt;
  logic [STOCK_W-1:0] stock5_cnt;
  logic               stock_en;
  logic [1:0]         sel_code;
  logic [5:0]         sel_val;

`ifdef CHANGE_DISPENSER_STOCK_EN
  logic [STOCK_W-1:0] stock10_q, stock10_d;
  logic [STOCK_W-1:0] stock5_q, stock5_d;

  // Refill is applied after the decrement so it wins on a shared edge.
  always_comb begin
    stock10_d = stock10_q;
    stock5_d  = stock5_q;
    if ((state_q == ST_ISSUE) && coin_ack) begin
      if (code_q == COIN_10) stock10_d = stock10_q - STOCK_W'(1);
      if (code_q == COIN_5)  stock5_d  = stock5_q - STOCK_W'(1);
    end
    if (refill) begin
      stock10_d = STOCK10_RST;
      stock5_d  = STOCK5_RST;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stock10_q <= STOCK10_RST;
      stock5_q  <= STOCK5_RST;
    end else begin
      stock10_q <= stock10_d;
      stock5_q  <= stock5_d;
    end
  end

  assign stock10_cnt = stock10_q;
  assign stock5_cnt  = stock5_q;
  assign stock_en    = 1'b1;
  assign stock10     = stock10_q;
  assign stock5      = stock5_q;
`else
  assign stock10_cnt = STOCK10_RST;
  assign stock5_cnt  = STOCK5_RST;
  assign stock_en    = 1'b0;
`endif

  coin_select #(
    .STOCK_W (STOCK_W)
  ) u_coin_select (
    .remaining (remaining_q),
    .stock10   (stock10_cnt),
    .stock5    (stock5_cnt),
    .stock_en  (stock_en),
    .coin_code (sel_code),
    .coin_val  (sel_val)
  );

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    code_d      = code_q;
    val_d       = val_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          remaining_d = req_amt;
          state_d     = (req_amt == 6'd0) ? ST_DONE : ST_PICK;
        end
      end
      ST_PICK: begin
        code_d  = sel_code;
        val_d   = sel_val;
        state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (coin_ack) begin
          remaining_d = remaining_q - val_q;
          state_d     = (remaining_q == val_q) ? ST_DONE : ST_PICK;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      remaining_q <= 6'd0;
      code_q      <= COIN_NONE;
      val_q       <= 6'd0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      code_q      <= code_d;
      val_q       <= val_d;
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign coin_valid = (state_q == ST_ISSUE);
  assign coin_code  = coin_valid ? code_q : COIN_NONE;
  assign remaining  = remaining_q;
  assign done       = (state_q == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_change_dispenser.sv
//==== tb_change_dispenser -- randomized payouts against a greedy-arithmetic reference model
//==== rev 1.0; build with CHANGE_DISPENSER_STOCK_EN to exercise stock counters and refill
`default_nettype none

module tb_change_dispenser;

  localparam int INIT10 = 8;
  localparam int INIT5  = 8;
`ifdef CHANGE_DISPENSER_STOCK_EN
  localparam bit STOCK_EN = 1'b1;
`else
  localparam bit STOCK_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic [5:0] req_amt = 6'd0;
  logic       coin_ack = 1'b0;
  logic       req_ready;
  logic       coin_valid;
  logic [1:0] coin_code;
  logic [5:0] remaining;
  logic       done;
`ifdef CHANGE_DISPENSER_STOCK_EN
  logic       refill = 1'b0;
  logic [3:0] stock10;
  logic [3:0] stock5;
`endif

  int n_vec = 0;
  int n_err = 0;
  int ms10  = INIT10;
  int ms5   = INIT5;

  always #5 clk = ~clk;

  change_dispenser dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_amt    (req_amt),
    .req_ready  (req_ready),
    .coin_valid (coin_valid),
    .coin_code  (coin_code),
    .coin_ack   (coin_ack),
    .remaining  (remaining),
    .done       (done)
`ifdef CHANGE_DISPENSER_STOCK_EN
    ,
    .refill     (refill),
    .stock10    (stock10),
    .stock5     (stock5)
`endif
  );

  // Greedy plan from counts: how many 10s and 5s fit, then emit the largest.
  function automatic int next_coin(input int m);
    int n10, n5;
    n10 = m / 10;
    if (STOCK_EN && n10 > ms10) n10 = ms10;
    m  = m - 10 * n10;
    n5 = m / 5;
    if (STOCK_EN && n5 > ms5) n5 = ms5;
    return (n10 > 0) ? 10 : ((n5 > 0) ? 5 : 1);
  endfunction

  function automatic logic [1:0] code_of(input int c);
    return (c == 10) ? 2'b11 : ((c == 5) ? 2'b10 : 2'b01);
  endfunction

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    ms10 = INIT10;
    ms5  = INIT5;
  endtask

  // One full request; optional ack stall, ack held high, refill on coin index, reset after coin index.
  task automatic do_req(input int amt, input int stall, input bit ack_hold,
                        input int reset_at, input int refill_at);
    int mrem, c, idx;
    n_vec++;
    if (req_ready !== 1'b1) begin n_err++; $display("FAIL req_ready_idle got %b want 1", req_ready); end
    coin_ack  = ack_hold;
    req_valid = 1'b1;
    req_amt   = 6'(amt);
    @(posedge clk); #1;
    req_valid = 1'b0;
    mrem = amt;
    if (amt == 0) begin
      n_vec++;
      if (done !== 1'b1 || coin_valid !== 1'b0) begin
        n_err++; $display("FAIL zero_done got done=%b valid=%b want done=1 valid=0", done, coin_valid);
      end
    end else begin
      n_vec++;
      if (coin_valid !== 1'b0 || remaining !== 6'(amt)) begin
        n_err++; $display("FAIL pick_latch got valid=%b rem=%0d want valid=0 rem=%0d", coin_valid, remaining, amt);
      end
    end
    idx = 0;
    while (mrem > 0) begin
      c = next_coin(mrem);
      @(posedge clk); #1;
      n_vec++;
      if (coin_valid !== 1'b1 || coin_code !== code_of(c) || remaining !== 6'(mrem)) begin
        n_err++; $display("FAIL issue got valid=%b code=%b rem=%0d want valid=1 code=%b rem=%0d",
                          coin_valid, coin_code, remaining, code_of(c), mrem);
      end
`ifdef CHANGE_DISPENSER_STOCK_EN
      if (idx == refill_at) refill = 1'b1;
`endif
      if (!ack_hold) begin
        for (int k = 0; k < stall; k++) begin
          req_valid = 1'b1;
          req_amt   = 6'($urandom);
          @(posedge clk); #1;
          if (idx == refill_at) begin ms10 = INIT10; ms5 = INIT5; end
          n_vec++;
          if (coin_valid !== 1'b1 || coin_code !== code_of(c) || remaining !== 6'(mrem)) begin
            n_err++; $display("FAIL stall got valid=%b code=%b rem=%0d want valid=1 code=%b rem=%0d",
                              coin_valid, coin_code, remaining, code_of(c), mrem);
          end
        end
        req_valid = 1'b0;
        coin_ack  = 1'b1;
      end
      @(posedge clk); #1;
      if (!ack_hold) coin_ack = 1'b0;
`ifdef CHANGE_DISPENSER_STOCK_EN
      refill = 1'b0;
`endif
      mrem = mrem - c;
      if (c == 10) ms10--;
      else if (c == 5) ms5--;
      if (idx == refill_at) begin ms10 = INIT10; ms5 = INIT5; end
      if (idx == reset_at) begin
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        coin_ack = 1'b0;
        ms10 = INIT10;
        ms5  = INIT5;
        n_vec++;
        if (coin_valid !== 1'b0 || remaining !== 6'd0 || done !== 1'b0 || req_ready !== 1'b1) begin
          n_err++; $display("FAIL mid_reset got valid=%b rem=%0d done=%b ready=%b want 0 0 0 1",
                            coin_valid, remaining, done, req_ready);
        end
        for (int k = 0; k < 3; k++) begin
          @(posedge clk); #1;
          n_vec++;
          if (done !== 1'b0) begin n_err++; $display("FAIL mid_reset_nodone got %b want 0", done); end
        end
        mrem = 0;
        break;
      end
      n_vec++;
      if (mrem == 0) begin
        if (done !== 1'b1 || coin_valid !== 1'b0 || remaining !== 6'd0) begin
          n_err++; $display("FAIL last_ack got done=%b valid=%b rem=%0d want 1 0 0", done, coin_valid, remaining);
        end
      end else if (coin_valid !== 1'b0 || done !== 1'b0) begin
        n_err++; $display("FAIL next_pick got valid=%b done=%b want 0 0", coin_valid, done);
      end
      idx++;
    end
    if (idx != reset_at || reset_at < 0) begin
      @(posedge clk); #1;
      n_vec++;
      if (done !== 1'b0 || req_ready !== 1'b1) begin
        n_err++; $display("FAIL done_pulse got done=%b ready=%b want 0 1", done, req_ready);
      end
    end
    coin_ack = 1'b0;
`ifdef CHANGE_DISPENSER_STOCK_EN
    n_vec++;
    if (stock10 !== 4'(ms10) || stock5 !== 4'(ms5)) begin
      n_err++; $display("FAIL stocks got s10=%0d s5=%0d want s10=%0d s5=%0d", stock10, stock5, ms10, ms5);
    end
`endif
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (coin_valid !== 1'b0 || coin_code !== 2'b00 || remaining !== 6'd0 || done !== 1'b0) begin
      n_err++; $display("FAIL reset_outputs got valid=%b code=%b rem=%0d done=%b want 0 00 0 0",
                        coin_valid, coin_code, remaining, done);
    end
    rst_n = 1'b1;
    ms10 = INIT10;
    ms5  = INIT5;
    @(posedge clk); #1;
    n_vec++;
    if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", req_ready); end
`ifdef CHANGE_DISPENSER_STOCK_EN
    n_vec++;
    if (stock10 !== 4'(INIT10) || stock5 !== 4'(INIT5)) begin
      n_err++; $display("FAIL reset_stocks got %0d %0d want %0d %0d", stock10, stock5, INIT10, INIT5);
    end
`endif
  endtask

  task automatic test_ack_high();
    apply_reset();
    do_req(25, 0, 1'b1, -1, -1);
  endtask

  task automatic test_zero();
    do_req(0, 0, 1'b0, -1, -1);
  endtask

  task automatic test_max();
    apply_reset();
    do_req(63, 0, 1'b0, -1, -1);
  endtask

  task automatic test_depletion();
    apply_reset();
    do_req(63, 0, 1'b0, -1, -1);
    do_req(10, 1, 1'b0, -1, -1);
    do_req(20, 0, 1'b0, -1, -1);
    do_req(10, 0, 1'b0, -1, -1);
  endtask

  task automatic test_stall();
    apply_reset();
    do_req(17, 5, 1'b0, -1, -1);
  endtask

  task automatic test_reset_mid();
    apply_reset();
    do_req(30, 1, 1'b0, 0, -1);
  endtask

  task automatic test_refill();
    apply_reset();
    do_req(45, 0, 1'b0, -1, -1);
    do_req(25, 2, 1'b0, -1, 0);
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 30; i++) begin
`ifdef CHANGE_DISPENSER_STOCK_EN
      if ($urandom_range(0, 4) == 0) begin
        refill = 1'b1;
        @(posedge clk); #1;
        refill = 1'b0;
        ms10 = INIT10;
        ms5  = INIT5;
      end
`endif
      do_req(($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 63)),
             int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
             -1, ($urandom_range(0, 5) == 0) ? 0 : -1);
    end
  endtask

  initial begin
    test_reset();
    test_ack_high();
    test_zero();
    test_max();
    test_depletion();
    test_stall();
    test_reset_mid();
    test_refill();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/change_dispenser.md
# change_dispenser

Downstream stage of the vending machine: accepts the change amount the machine returns after a sale or cancel and pays it out as physical coins, one at a time, to the coin-ejector mechanism. It uses greedy coin selection (10, 5, 1) with a valid/ack handshake per coin, tracks the coin inventory, and signals completion. The vending machine writes a 6-bit change value. This block holds it and drains it over as many cycles as the ejector needs.

## Interface
- `STOCK10_INIT`, default 8: 10-unit coins loaded at reset or refill.
- `STOCK5_INIT`, default 8: 5-unit coins loaded at reset or refill.
- `STOCK_W`, default 4: width of the stock counters. Must hold the INIT values.
- `clk` input, 1: single clock. All state changes on the rising edge.
- `rst_n` input, 1: synchronous, active-low reset.
- `req_valid` input, 1: a change amount is presented.
- `req_amt` input, 6: the change amount, 0..63.
- `req_ready` output, 1: high only in IDLE. A request is accepted on an edge where `req_valid && req_ready`.
- `coin_valid` output, 1: a coin is offered to the ejector.
- `coin_code` output, 2: 01 = 1, 10 = 5, 11 = 10, 00 = none. Stable while `coin_valid` is high.
- `coin_ack` input, 1: the ejector took the coin. Ignored unless `coin_valid` is high.
- `remaining` output, 6: change still owed. Includes the coin currently offered.
- `done` output, 1: one-cycle pulse when the payout is complete.
- `refill` input, 1: reloads the stocks. Present only with the macro enabled.
- `stock10` output, STOCK_W: 10-unit coin count. Present only with the macro enabled.
- `stock5` output, STOCK_W: 5-unit coin count. Present only with the macro enabled.

## Operation
- States: IDLE, PICK, ISSUE, DONE.
- IDLE:
  - `req_ready` = 1.
  - On acceptance, latch `req_amt` into `remaining`.
  - Go to DONE if `req_amt` = 0, otherwise go to PICK.
- PICK: select the coin combinationally, then go to ISSUE.
  - Choose 10 if `remaining` ≥ 10 and `stock10` > 0.
  - Else choose 5 if `remaining` ≥ 5 and `stock5` > 0.
  - Else choose 1. The 1-unit supply is unlimited.
- ISSUE:
  - `coin_valid` = 1. `coin_code` holds the registered choice.
  - On `coin_ack`: subtract the coin value from `remaining` and decrement the matching stock.
  - Then go to DONE if the new `remaining` = 0, else go to PICK.
  - Without `coin_ack`, hold the state and all outputs unchanged.
- DONE: `done` = 1 for exactly one cycle, then go to IDLE.
- Arithmetic:
  - `remaining` is 6-bit unsigned and never underflows, because the selected coin value is always ≤ `remaining`.
  - Stocks never go below 0, because a coin is chosen only when its stock > 0.
- Boundary conditions:
  - `req_valid` while not in IDLE is ignored. The requester holds it.
  - `coin_ack` outside ISSUE is ignored.
  - A `refill` in the same cycle as a decrement wins: the stock ends at its INIT value.
  - Refill during ISSUE does not change the coin already on offer.
  - `rst_n` low at any edge, including mid-payout, returns to IDLE. Any unpaid `remaining` is discarded.

## Timing
- Reset values:
  - State IDLE.
  - `req_ready` = 1 (effective after reset is released).
  - `coin_valid` = 0, `coin_code` = 00, `remaining` = 0, `done` = 0.
  - `stock10` = `STOCK10_INIT`, `stock5` = `STOCK5_INIT`.
- Edge sequence for a request accepted at edge E0:
  - E0: state becomes PICK.
  - E1: ISSUE; `coin_valid` rises after E1.
  - First `coin_ack` sampled at E2.
- Per coin: minimum 2 cycles (PICK + ISSUE).
- Completion: `done` is high in the cycle after the edge that samples the last ack. `req_ready` returns the following cycle.
- Zero request: `done` is high in the cycle after acceptance. No `coin_valid` is ever asserted.
- All outputs are registered or decoded from state. There is no combinational path from `coin_ack` to `coin_valid`.

## Configuration
- Macro: `CHANGE_DISPENSER_STOCK_EN`.
- Defined:
  - Stock counters, `refill`, `stock10` and `stock5` exist.
  - Selection honours the stock rules above.
- Undefined:
  - No counters and no stock ports.
  - 10 and 5 coins are treated as unlimited.
  - Selection is pure greedy on `remaining`.

## Structure
- Shared package `change_disp_pkg` holds:
  - Coin-code constants: `COIN_NONE`, `COIN_1`, `COIN_5`, `COIN_10`.
  - Coin value constants: 1, 5, 10.
  - The state typedef (IDLE/PICK/ISSUE/DONE).
- One sub-module, `coin_select`:
  - Combinational.
  - Inputs: `remaining`, the stock counts, and the stock-enable flags.
  - Outputs: `coin_code` and the coin value.
- The FSM, `remaining` register and stock counters live in `change_dispenser`.

## Test plan
- Full stock, ack tied high, request 25 → coins 10, 10, 5; one `done` pulse; `stock10` = 6, `stock5` = 7.
- Request 0 → `done` one cycle after acceptance; `coin_valid` never high; stocks unchanged.
- Request 63, full stock → six 10s then three 1s; `remaining` steps 63, 53, 43, 33, 23, 13, 3, 2, 1, 0.
- Stock depletion: set `stock10` = 1, request 20 → 10, 5, 5; `stock10` = 0; next request 10 → 5, 5.
- Ack stall: hold `coin_ack` low for 5 cycles during ISSUE → `coin_valid` and `coin_code` stable, `remaining` unchanged; ack → normal progress.
- Reset mid-payout: request 30, drop `rst_n` after the first ack → IDLE, `remaining` = 0, stocks at INIT, no `done` pulse.
